// File: rtl/in_pcm.sv
// -----------------------------------------------------------------------------
// in_pcm : input PCM conversion stage of a G.726-style ADPCM encoder.
//
// This block takes one 8-bit log-PCM sample per clock. The sample can be A-law
// or mu-law. The block expands it to 14-bit two's-complement linear PCM (SL).
// It then subtracts the 15-bit signal estimate SE to give the 16-bit
// difference signal D. The datapath is purely combinational up to one output
// register, so D has one cycle of latency. A new sample is accepted on every
// clock and there is no handshake.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous, active-high reset; takes priority over the load
//   S      in   8   log-PCM sample as carried on the line (not pre-inverted)
//   SE     in  15   signal estimate, two's complement
//   LAW    in   1   companding select: 0 = mu-law, 1 = A-law
//   D      out 16   registered difference SL - SE, two's complement
//   SL     out 14   registered expanded linear sample (only when
//                   IN_PCM_SL_PORT_EN is defined; used for debug and by the
//                   tone/transition detector)
//
// Configuration macro: IN_PCM_SL_PORT_EN. When it is not defined, SL stays
// internal and D behaves exactly the same.
// -----------------------------------------------------------------------------
module in_pcm (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  S,
  input  logic [14:0] SE,
  input  logic        LAW,
  output logic [15:0] D
`ifdef IN_PCM_SL_PORT_EN
  ,
  output logic [13:0] SL
`endif
);

  // Fields of the de-inverted code word for each law.
  logic [7:0]  mu_word;
  logic [7:0]  a_word;
  logic        sign;      // 1 = negative
  logic [2:0]  seg;
  logic [3:0]  quant;

  // Expanded magnitudes. The largest values are 8031 (mu-law) and
  // 8064 (A-law), so both fit in 14 bits without wrapping.
  logic [13:0] mu_mag;
  logic [12:0] a_m;
  logic [13:0] a_mag;
  logic [13:0] mag;

  logic [13:0] sl_d;
  logic [15:0] d_d;
  logic [15:0] d_q;

  // Expansion and subtraction.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, starting with
    // these defaults, so synthesis cannot infer a latch for any S/LAW value.
    mu_word = ~S;
    a_word  = S ^ 8'h55;
    sign    = 1'b0;
    seg     = 3'd0;
    quant   = 4'd0;
    mu_mag  = 14'd0;
    a_m     = 13'd0;
    a_mag   = 14'd0;
    mag     = 14'd0;

    if (LAW == 1'b0) begin
      // mu-law: the bias of 33 is added before the segment shift and removed
      // after it. With this the code for zero (0xFF on the line) gives exactly 0.
      sign   = mu_word[7];
      seg    = mu_word[6:4];
      quant  = mu_word[3:0];
      mu_mag = ((14'({quant, 1'b0}) + 14'd33) << seg) - 14'd33;
      mag    = mu_mag;
    end else begin
      // A-law: in segment 0 the step is linear and has no implied leading 1.
      // The segments above 0 carry the leading 1 (the +32 inside 2q+33) and
      // shift by seg-1. The final shift by 1 scales the result to the 14-bit
      // range. The sign bit has the opposite sense from mu-law.
      sign  = ~a_word[7];
      seg   = a_word[6:4];
      quant = a_word[3:0];
      if (seg == 3'd0) begin
        a_m = {8'd0, quant, 1'b1};
      end else begin
        a_m = (13'({quant, 1'b0}) + 13'd33) << (seg - 3'd1);
      end
      a_mag = {a_m, 1'b0};
      mag   = a_mag;
    end

    // When the mu-law code is negative zero, mag is 0, and 0 - 0 is still 0.
    sl_d = sign ? (14'd0 - mag) : mag;

    // Both operands are sign-extended to 16 bits. Their ranges
    // (|SL| <= 8064, SE in -16384..16383) mean the difference cannot wrap.
    d_d  = {{2{sl_d[13]}}, sl_d} - {SE[14], SE};
  end

  // Output register.
  always_ff @(posedge clk) begin
    // NOTE: registered state is always written with non-blocking assignments.
    // Every flop then samples values from before the edge, whatever order the
    // blocks are evaluated in.
    if (reset) begin
      d_q <= 16'h0000;
    end else begin
      d_q <= d_d;
    end
  end

  assign D = d_q;

`ifdef IN_PCM_SL_PORT_EN
  logic [13:0] sl_q;

  // SL is registered alongside D so the two stay aligned to the same sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sl_q <= 14'h0000;
    end else begin
      sl_q <= sl_d;
    end
  end

  assign SL = sl_q;
`endif

endmodule

// File: tb/tb_in_pcm.sv
// -----------------------------------------------------------------------------
// tb_in_pcm : self-checking bench for in_pcm.
// Directed extremes use fixed expected constants. The streaming and random
// steps are compared against an arithmetic model of the companding rules.
// When IN_PCM_SL_PORT_EN is defined, SL is checked as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_in_pcm;

  logic        clk;
  logic        reset;
  logic [7:0]  S;
  logic [14:0] SE;
  logic        LAW;
  logic [15:0] D;
`ifdef IN_PCM_SL_PORT_EN
  logic [13:0] SL;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  in_pcm dut (
    .clk   (clk),
    .reset (reset),
    .S     (S),
    .SE    (SE),
    .LAW   (LAW),
    .D     (D)
`ifdef IN_PCM_SL_PORT_EN
    ,
    .SL    (SL)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: linear value straight from the law definitions, using integers.
  function automatic int model_sl(logic [7:0] s, logic law);
    logic [7:0] w;
    int seg, q, mag;
    bit neg;
    if (!law) begin
      w   = ~s;
      neg = w[7];
      seg = int'(w[6:4]);
      q   = int'(w[3:0]);
      mag = (2 * q + 33) * (2 ** seg) - 33;
    end else begin
      w   = s ^ 8'h55;
      neg = !w[7];
      seg = int'(w[6:4]);
      q   = int'(w[3:0]);
      if (seg == 0) mag = 2 * (2 * q + 1);
      else          mag = 2 * ((2 * q + 33) * (2 ** (seg - 1)));
    end
    return neg ? -mag : mag;
  endfunction

  function automatic logic [15:0] model_d(logic [7:0] s, logic [14:0] se, logic law);
    int sl, sev;
    sl  = model_sl(s, law);
    sev = int'($signed(se));
    return 16'(sl - sev);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one sample, waits for the capturing edge, then samples 1 ns later.
  task automatic step(input string tag, input logic rst, input logic [7:0] s,
                      input logic [14:0] se, input logic law, input logic [15:0] exp_d,
                      input logic [13:0] exp_sl);
    reset = rst;
    S     = s;
    SE    = se;
    LAW   = law;
    @(posedge clk);
    #1;
    check(tag, D, exp_d);
`ifdef IN_PCM_SL_PORT_EN
    check({tag, "_sl"}, {2'b00, SL}, {2'b00, exp_sl});
`endif
  endtask

  // Step whose expected values come from the model.
  task automatic step_m(input string tag, input logic rst, input logic [7:0] s,
                        input logic [14:0] se, input logic law);
    logic [15:0] ed;
    logic [13:0] es;
    ed = rst ? 16'h0000 : model_d(s, se, law);
    es = rst ? 14'h0000 : 14'(model_sl(s, law));
    step(tag, rst, s, se, law, ed, es);
  endtask

  initial begin
    logic [7:0]  rs;
    logic [14:0] rse;
    logic        rlaw;
    logic [7:0]  stream [8];

    reset = 1'b1;
    S     = 8'h80;
    SE    = 15'h0000;
    LAW   = 1'b0;
    #1;

    // Reset held: D stays 0.
    step("reset0", 1'b1, 8'h80, 15'h0000, 1'b0, 16'h0000, 14'h0000);
    step("reset1", 1'b1, 8'h80, 15'h0000, 1'b0, 16'h0000, 14'h0000);
    step("reset2", 1'b1, 8'h80, 15'h0000, 1'b0, 16'h0000, 14'h0000);
    step("release", 1'b0, 8'h80, 15'h0000, 1'b0, 16'h1F5F, 14'h1F5F);

    // mu-law extremes.
    step("mu_pos0", 1'b0, 8'hFF, 15'h0000, 1'b0, 16'h0000, 14'h0000);
    step("mu_neg0", 1'b0, 8'h7F, 15'h0000, 1'b0, 16'h0000, 14'h0000);
    step("mu_max",  1'b0, 8'h80, 15'h0000, 1'b0, 16'h1F5F, 14'h1F5F);
    step("mu_min",  1'b0, 8'h00, 15'h0000, 1'b0, 16'hE0A1, 14'h20A1);

    // A-law extremes.
    step("a_pmin", 1'b0, 8'hD5, 15'h0000, 1'b1, 16'h0002, 14'h0002);
    step("a_nmin", 1'b0, 8'h55, 15'h0000, 1'b1, 16'hFFFE, 14'h3FFE);
    step("a_max",  1'b0, 8'hAA, 15'h0000, 1'b1, 16'h1F80, 14'h1F80);
    step("a_min",  1'b0, 8'h2A, 15'h0000, 1'b1, 16'hE080, 14'h2080);

    // SE subtraction at both ends of the estimate range.
    step("se_max", 1'b0, 8'h80, 15'h3FFF, 1'b0, 16'hDF60, 14'h1F5F);
    step("se_min", 1'b0, 8'h80, 15'h4000, 1'b0, 16'h5F5F, 14'h1F5F);

    // Back-to-back stream of 8 distinct samples, LAW toggles after the 4th.
    stream[0] = 8'h12; stream[1] = 8'h9C; stream[2] = 8'h47; stream[3] = 8'hE3;
    stream[4] = 8'h3A; stream[5] = 8'hB1; stream[6] = 8'h6D; stream[7] = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      step_m($sformatf("stream%0d", i), 1'b0, stream[i], 15'(i * 1000), (i >= 4));
    end

    // Random stream with a single-cycle reset inserted in the middle.
    for (int i = 0; i < 40; i++) begin
      rs   = 8'($urandom);
      rse  = 15'($urandom);
      rlaw = 1'($urandom);
      step_m($sformatf("rand%0d", i), (i == 20), rs, rse, rlaw);
    end

    // Sweep every code in both laws against the model.
    for (int i = 0; i < 256; i++) begin
      step_m($sformatf("sweep_mu%0d", i), 1'b0, 8'(i), 15'($urandom), 1'b0);
      step_m($sformatf("sweep_a%0d", i), 1'b0, 8'(i), 15'($urandom), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/in_pcm.md
Name: in_pcm

Overview:
- Input PCM conversion stage of a G.726-style ADPCM encoder (EXPAND + SUBTA).
- Converts an 8-bit log-PCM sample (A-law or µ-law, selected by LAW) to 14-bit two's-complement linear PCM SL.
- Subtracts the signal estimate SE to produce the 16-bit difference signal D.
- Sits between the PCM input interface and the adaptive quantizer; output is registered.

Parameters:
- none (all widths fixed by the G.726 format).

Ports:
- clk    input   1   system clock; all state updates on rising edge.
- reset  input   1   synchronous, active-high reset.
- S      input   8   log-PCM input sample, as transmitted on the line (not pre-inverted).
- SE     input   15  signal estimate, two's complement.
- LAW    input   1   companding select: 0 = µ-law, 1 = A-law.
- D      output  16  difference signal SL - SE, two's complement, registered.

Behaviour:
- Datapath is purely combinational from S/SE/LAW to next_D; D is a register.
- Latency: D reflects the inputs sampled at the previous rising clk edge (1 cycle).
- New sample accepted every cycle; no handshake.
- Reset: on a rising clk edge with reset=1, D <= 16'h0000. Reset has priority over the data load.
- Reset mid-stream: the output is 0 for each reset cycle. The first valid D appears one cycle after the first non-reset edge.
- LAW may change on any cycle and takes effect on the sample captured at that edge.
- µ-law (LAW=0):
  - I = ~S; sign = I[7] (1 = negative); seg = I[6:4]; q = I[3:0].
  - mag = ((2*q + 33) << seg) - 33; range 0..8031.
- A-law (LAW=1):
  - I = S ^ 8'h55; sign = ~I[7] (1 = negative); seg = I[6:4]; q = I[3:0].
  - m = (seg==0) ? (2*q + 1) : ((2*q + 33) << (seg-1)); range 1..4032.
  - mag = m << 1; range 2..8064.
- SL = sign ? -mag : mag, as 14-bit two's complement. µ-law negative zero yields SL = 0.
- D = sext16(SL) - sext16(SE), modulo 2^16. No saturation; the operand ranges guarantee no overflow.
- No X propagation: all intermediate signals are fully assigned for every S/LAW combination.

Optional Feature:
- Macro: IN_PCM_SL_PORT_EN.
- Defined:
  - Adds an output port SL [13:0], registered in parallel with D with the same latency.
  - SL resets to 0 and carries the expanded linear sample.
  - Used for debug and for the tone/transition detector.
- Undefined: no SL port. The SL value is internal only; D behaviour is identical.

Test Plan:
- Reset: hold reset=1 with S=8'h80, SE=15'h0000, LAW=0 → D=16'h0000 every cycle. Release reset → D=16'h1F5F one cycle later.
- µ-law extremes, SE=0, LAW=0:
  - S=8'hFF → D=16'h0000 (+0).
  - S=8'h7F → D=16'h0000 (-0).
  - S=8'h80 → D=16'h1F5F (+8031).
  - S=8'h00 → D=16'hE0A1 (-8031).
- A-law extremes, SE=0, LAW=1:
  - S=8'hD5 → D=16'h0002.
  - S=8'h55 → D=16'hFFFE.
  - S=8'hAA → D=16'h1F80 (+8064).
  - S=8'h2A → D=16'hE080.
- SE subtraction, LAW=0, S=8'h80:
  - SE=15'h3FFF → D=16'hDF60 (8031-16383).
  - SE=15'h4000 (-16384) → D=16'h5F5F.
- Back-to-back streaming and law switch:
  - Apply 8 consecutive distinct samples, toggling LAW after the 4th.
  - Each D matches the model one cycle after its input; no bubbles, and no stale value across the LAW change.
- Reset mid-stream: assert reset for one cycle during a random vector stream → D=0 for that cycle, then the correct results resume one cycle after the inputs following deassertion.
